// File: rtl/full_adder_beha.sv
// rtl/full_adder_beha.sv - registered ripple-carry full adder
// A chain of one-bit cells forms a + b + c; the result lands in output flops one clock later.
module full_adder_beha #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_w;
    logic             carry_w;
    logic             msb_cin_w;

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             out_valid_d, out_valid_q;

    // carry_w walks the chain; msb_cin_w keeps the carry into the top cell for signed overflow
    always_comb begin
        sum_w     = '0;
        carry_w   = c;
        msb_cin_w = c;
        for (int i = 0; i < WIDTH; i++) begin
            msb_cin_w = carry_w;
            sum_w[i]  = a[i] ^ b[i] ^ carry_w;
            carry_w   = (a[i] & b[i]) | (a[i] & carry_w) | (b[i] & carry_w);
        end
    end

    always_comb begin
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s_d    = sum_w;
            cout_d = carry_w;
            ovf_d  = carry_w ^ msb_cin_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_beha.sv
// tb/tb_full_adder_beha.sv - directed checks of full_adder_beha at WIDTH=1 and WIDTH=8
module tb_full_adder_beha;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       v1, a1, b1, c1;
    logic       s1, co1, ov1, ov_1;

    logic       v8, c8;
    logic [7:0] a8, b8, s8;
    logic       co8, ovf8, ov_8;

    full_adder_beha #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c(c1),
        .s(s1), .cout(co1), .ovf(ov1), .out_valid(ov_1)
    );

    full_adder_beha #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c(c8),
        .s(s8), .cout(co8), .ovf(ovf8), .out_valid(ov_8)
    );

    typedef struct {
        logic a, b, c;
        logic s, cout, ovf;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       c;
        logic [7:0] s;
        logic       cout, ovf;
    } vec8_t;

    vec1_t t1[8];
    vec8_t t8[3];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] ref_sum;
    logic       ref_ovf;

    initial begin
        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        t1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        t8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        t8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;

        #12;
        check("reset_w1", {s1, co1, ov1, ov_1}, 4'b0000);
        check("reset_w8", {s8, co8, ovf8, ov_8}, 11'h000);
        rst_n = 1'b1;
        step();

        // WIDTH=1 exhaustive sweep
        for (int i = 0; i < 8; i++) begin
            v1 = 1'b1; a1 = t1[i].a; b1 = t1[i].b; c1 = t1[i].c;
            step();
            check($sformatf("w1_s_%0d", i),    s1,   t1[i].s);
            check($sformatf("w1_cout_%0d", i), co1,  t1[i].cout);
            check($sformatf("w1_ovf_%0d", i),  ov1,  t1[i].ovf);
            check($sformatf("w1_ov_%0d", i),   ov_1, 1'b1);
        end

        // asynchronous reset after capturing 111
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        step();
        check("pre_reset_s_cout", {s1, co1}, 2'b11);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_w1", {s1, co1, ov1, ov_1}, 4'b0000);
        v1 = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        check("post_reset_1", {s1, co1, ov1, ov_1}, 4'b0000);
        step();
        check("post_reset_2", {s1, co1, ov1, ov_1}, 4'b0000);

        // hold while in_valid is low
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        step();
        check("hold_capture", {s1, co1, ov1, ov_1}, 4'b0111);
        for (int i = 0; i < 5; i++) begin
            v1 = 1'b0;
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            c1 = 1'($urandom_range(0, 1));
            step();
            check($sformatf("hold_%0d", i), {s1, co1, ov1, ov_1}, 4'b0110);
        end

        // WIDTH=8 directed arithmetic
        for (int i = 0; i < 3; i++) begin
            v8 = 1'b1; a8 = t8[i].a; b8 = t8[i].b; c8 = t8[i].c;
            step();
            check($sformatf("w8_s_%0d", i),    s8,   t8[i].s);
            check($sformatf("w8_cout_%0d", i), co8,  t8[i].cout);
            check($sformatf("w8_ovf_%0d", i),  ovf8, t8[i].ovf);
            check($sformatf("w8_ov_%0d", i),   ov_8, 1'b1);
        end

        // WIDTH=8 back-to-back streaming
        for (int i = 0; i < 100; i++) begin
            v8 = 1'b1;
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            c8 = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, a8} + {1'b0, b8} + {8'h00, c8};
            ref_ovf = (a8[7] == b8[7]) && (ref_sum[7] != a8[7]);
            step();
            check($sformatf("stream_sum_%0d", i), {co8, s8}, ref_sum);
            check($sformatf("stream_ovf_%0d", i), ovf8, ref_ovf);
            check($sformatf("stream_ov_%0d", i),  ov_8, 1'b1);
        end

        v8 = 1'b0;
        step();
        check("stream_end_ov", ov_8, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/full_adder_beha.md
Name: full_adder_beha

Overview:
Registered ripple-carry full adder. At WIDTH=1 it is the classic one-bit full adder: sum = a^b^c, carry = majority(a,b,c). Operands are added combinationally through a chain of one-bit full-adder cells. The result is captured in output registers on the clock edge. It is the arithmetic leaf cell used by wider datapath blocks.

Parameters:
WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  qualifies a, b, c for capture this cycle.
a  input  WIDTH  operand A (unsigned; also interpreted as two's-complement for ovf).
b  input  WIDTH  operand B.
c  input  1  carry-in, added at bit 0.
s  output  WIDTH  registered sum bits.
cout  output  1  registered carry-out of the MSB cell.
ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
out_valid  output  1  registered copy of in_valid; marks s/cout/ovf as updated this cycle.

Behaviour:
- Cell i computes:
  - sum_i = a[i] ^ b[i] ^ k[i]
  - k[i+1] = (a[i]&b[i]) | (a[i]&k[i]) | (b[i]&k[i])
  - k[0] = c
- Combinational total = a + b + c, giving WIDTH+1 bits {k[WIDTH], sum}. The result is exact, with no saturation and no truncation beyond WIDTH+1 bits.
- ovf = k[WIDTH] ^ k[WIDTH-1]. At WIDTH=1, k[0] is c, so ovf = cout ^ c.
- Reset:
  - rst_n low forces s=0, cout=0, ovf=0, out_valid=0 immediately, with no clock required.
  - Outputs hold these values while rst_n is low.
  - Deassertion is sampled by the first rising edge with rst_n high.
- Capture:
  - At a rising edge with rst_n high and in_valid=1, s, cout and ovf load the combinational result of the a/b/c present at that edge.
  - Latency is 1 clock: the result is visible after the edge and stable for the whole next cycle.
- Hold: at a rising edge with in_valid=0, s, cout and ovf keep their previous values.
- out_valid <= in_valid on every rising edge, so it is 1 for exactly the cycles following a capture.
- Back-to-back: in_valid held at 1 gives one new result per cycle. There are no bubbles and no backpressure.
- Reset mid-operation: any pending capture is lost. Outputs read 0 until the next valid capture after release.
- Wrap-around:
  - All-ones + all-ones + 1 gives s = all-ones and cout=1.
  - All-ones + 0 + 1 gives s=0 and cout=1.
- Inputs are fully synchronous to clk. X on inputs while in_valid=0 must not disturb the outputs.

Test Plan:
- WIDTH=1 exhaustive sweep, in_valid=1, 10-unit steps (capture the result each cycle, in order):
  - (a,b,c)=000 gives s=0, cout=0
  - 001 gives s=1, cout=0
  - 010 gives s=1, cout=0
  - 011 gives s=0, cout=1
  - 100 gives s=1, cout=0
  - 101 gives s=0, cout=1
  - 110 gives s=0, cout=1
  - 111 gives s=1, cout=1
  - Each result appears one cycle after its inputs, with out_valid=1.
- Reset: drive rst_n=0 mid-cycle after a capture of 111. s, cout, ovf and out_valid go to 0 at once, before any clock edge. After release with in_valid=0, outputs stay 0.
- Hold: capture a=1, b=1, c=0 (s=0, cout=1), then drop in_valid and toggle a/b/c randomly for 5 cycles. s=0, cout=1 remain and out_valid=0.
- WIDTH=8 arithmetic:
  - a=0xFF, b=0x01, c=0 gives s=0x00, cout=1, ovf=0.
  - a=0x7F, b=0x01, c=0 gives s=0x80, cout=0, ovf=1.
  - a=0xFF, b=0xFF, c=1 gives s=0xFF, cout=1, ovf=0.
- WIDTH=8 streaming: in_valid=1 for 100 consecutive random (a,b,c). Each cycle {cout,s} equals the previous cycle's a+b+c, and ovf matches the signed-overflow reference.
